// File: rtl/loop_disable_ctrl_pkg.sv
// loop_disable_ctrl_pkg: shared state/exit-cause types and the forever-mode count value
package loop_ctrl_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_EXIT} loop_state_e;
  typedef enum logic {EXIT_NATURAL, EXIT_DISABLE} exit_cause_e;
  localparam int FOREVER_CNT = 0;
endpackage

// File: rtl/loop_disable_ctrl_if.sv
// loop_disable_ctrl_if: flattened per-channel control/status bundle; wd_fire exists only with LOOP_WATCHDOG_EN
interface loop_disable_ctrl_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8,
  parameter int DATA_W = 32
);
  logic [NUM_CH-1:0]        start;
  logic [NUM_CH*CNT_W-1:0]  count;
  logic [NUM_CH-1:0]        dis;
  logic [NUM_CH*DATA_W-1:0] o_data;
  logic [NUM_CH-1:0]        busy;
  logic [NUM_CH-1:0]        done;
  logic [NUM_CH-1:0]        exit_dis;
  logic [NUM_CH*CNT_W-1:0]  iter;
`ifdef LOOP_WATCHDOG_EN
  logic [NUM_CH-1:0]        wd_fire;
  modport master (output start, count, dis, input o_data, busy, done, exit_dis, iter, wd_fire);
  modport slave  (input start, count, dis, output o_data, busy, done, exit_dis, iter, wd_fire);
`else
  modport master (output start, count, dis, input o_data, busy, done, exit_dis, iter);
  modport slave  (input start, count, dis, output o_data, busy, done, exit_dis, iter);
`endif
endinterface

// File: rtl/loop_disable_ctrl_ch.sv
// loop_ch: one loop channel (FSM, iteration counter, data register, optional LOOP_WATCHDOG_EN watchdog)
module loop_ch
  import loop_ctrl_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int DATA_W   = 32,
  parameter int INIT_VAL = 1,
  parameter int LOOP_VAL = 10
`ifdef LOOP_WATCHDOG_EN
  , parameter int WD_W   = 12
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  count,
  input  logic              dis,
  output logic [DATA_W-1:0] o_data,
  output logic              busy,
  output logic              done,
  output logic              exit_dis,
  output logic [CNT_W-1:0]  iter
`ifdef LOOP_WATCHDOG_EN
  , output logic            wd_fire
`endif
);
  loop_state_e state_q, state_d;
  exit_cause_e cause_q, cause_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, iter_q, iter_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic forever_m, wd_hit, brk, last;
  assign forever_m = cnt_q == CNT_W'(FOREVER_CNT);
`ifdef LOOP_WATCHDOG_EN
  logic [WD_W-1:0] wd_q, wd_d;
  logic fire_q, fire_d;
  assign wd_hit = state_q == ST_RUN && forever_m && wd_q == '1;
  assign wd_d = (state_q == ST_IDLE && start) ? '0 : (state_q == ST_RUN && forever_m) ? wd_q + 1'b1 : wd_q;
  assign fire_d = state_q == ST_RUN ? wd_hit : fire_q;
  assign wd_fire = done && fire_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wd_q   <= '0;
      fire_q <= 1'b0;
    end else begin
      wd_q   <= wd_d;
      fire_q <= fire_d;
    end
`else
  assign wd_hit = 1'b0;
`endif
  // a break suppresses the iteration of the cycle it arrives in
  assign brk  = dis || wd_hit;
  assign last = !forever_m && iter_q + CNT_W'(1) == cnt_q;
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    cnt_d   = cnt_q;
    iter_d  = iter_q;
    data_d  = data_q;
    if (state_q == ST_IDLE && start) begin
      state_d = ST_RUN;
      cnt_d   = count;
      iter_d  = '0;
    end else if (state_q == ST_RUN && brk) begin
      state_d = ST_EXIT;
      cause_d = EXIT_DISABLE;
    end else if (state_q == ST_RUN) begin
      data_d  = DATA_W'(LOOP_VAL) + DATA_W'(iter_q);
      iter_d  = iter_q + CNT_W'(1);
      state_d = last ? ST_EXIT : ST_RUN;
      cause_d = EXIT_NATURAL;
    end else if (state_q == ST_EXIT) begin
      state_d = ST_IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cause_q <= EXIT_NATURAL;
      cnt_q   <= '0;
      iter_q  <= '0;
      data_q  <= DATA_W'(INIT_VAL);
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
      iter_q  <= iter_d;
      data_q  <= data_d;
    end
  assign busy     = state_q == ST_RUN;
  assign done     = state_q == ST_EXIT;
  assign exit_dis = done && cause_q == EXIT_DISABLE;
  assign o_data   = data_q;
  assign iter     = iter_q;
endmodule

// File: rtl/loop_disable_ctrl.sv
// loop_disable_ctrl: NUM_CH independent loop channels sliced from a flat bus; LOOP_WATCHDOG_EN adds a forever-loop watchdog
module loop_disable_ctrl
  import loop_ctrl_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 8,
  parameter int DATA_W   = 32,
  parameter int INIT_VAL = 1,
  parameter int LOOP_VAL = 10
`ifdef LOOP_WATCHDOG_EN
  , parameter int WD_W   = 12
`endif
) (
  input logic clk,
  input logic rst_n,
  loop_disable_ctrl_if.slave bus
);
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    loop_ch #(
      .CNT_W(CNT_W), .DATA_W(DATA_W), .INIT_VAL(INIT_VAL), .LOOP_VAL(LOOP_VAL)
`ifdef LOOP_WATCHDOG_EN
      , .WD_W(WD_W)
`endif
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (bus.start[c]),
      .count    (bus.count[c*CNT_W +: CNT_W]),
      .dis      (bus.dis[c]),
      .o_data   (bus.o_data[c*DATA_W +: DATA_W]),
      .busy     (bus.busy[c]),
      .done     (bus.done[c]),
      .exit_dis (bus.exit_dis[c]),
      .iter     (bus.iter[c*CNT_W +: CNT_W])
`ifdef LOOP_WATCHDOG_EN
      , .wd_fire(bus.wd_fire[c])
`endif
    );
  end
endmodule

// File: tb/tb_loop_disable_ctrl.sv
// tb_loop_disable_ctrl: directed scenarios plus random start/count/dis traffic against a per-channel loop model
module tb_loop_disable_ctrl;
  localparam int NUM_CH = 4, CNT_W = 8, DATA_W = 32, INIT_VAL = 1, LOOP_VAL = 10;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  loop_disable_ctrl_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DATA_W(DATA_W)) bus ();
  loop_disable_ctrl #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DATA_W(DATA_W), .INIT_VAL(INIT_VAL), .LOOP_VAL(LOOP_VAL))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  bit m_run[NUM_CH], m_fin[NUM_CH], m_dis[NUM_CH];
  int m_n[NUM_CH], m_lim[NUM_CH], m_dat[NUM_CH];
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic void m_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_run[c] = 0; m_fin[c] = 0; m_dis[c] = 0;
      m_n[c] = 0; m_lim[c] = 0; m_dat[c] = INIT_VAL;
    end
  endfunction
  // advance the model by one clock using the inputs currently on the bus
  function automatic void m_step();
    for (int c = 0; c < NUM_CH; c++) begin
      if (m_fin[c]) m_fin[c] = 0;
      else if (!m_run[c]) begin
        if (bus.start[c]) begin
          m_run[c] = 1; m_n[c] = 0; m_lim[c] = int'(bus.count[c*CNT_W +: CNT_W]);
        end
      end else if (bus.dis[c]) begin
        m_run[c] = 0; m_fin[c] = 1; m_dis[c] = 1;
      end else begin
        m_dat[c] = LOOP_VAL + m_n[c];
        m_n[c] = (m_n[c] + 1) % (1 << CNT_W);
        if (m_lim[c] != 0 && m_n[c] == m_lim[c]) begin
          m_run[c] = 0; m_fin[c] = 1; m_dis[c] = 0;
        end
      end
    end
  endfunction
  task automatic check_all(input string tag);
    logic [127:0] e_data;
    logic [31:0] e_iter;
    logic [3:0] e_busy, e_done, e_ed;
    e_data = '0; e_iter = '0; e_busy = '0; e_done = '0; e_ed = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      e_data[c*DATA_W +: DATA_W] = DATA_W'(m_dat[c]);
      e_iter[c*CNT_W +: CNT_W] = CNT_W'(m_n[c]);
      e_busy[c] = m_run[c];
      e_done[c] = m_fin[c];
      e_ed[c] = m_fin[c] && m_dis[c];
    end
    check({tag, "/data"}, bus.o_data, e_data);
    check({tag, "/iter"}, bus.iter, e_iter);
    check({tag, "/busy"}, bus.busy, e_busy);
    check({tag, "/done"}, bus.done, e_done);
    check({tag, "/exit_dis"}, bus.exit_dis, e_ed);
  endtask
  task automatic cyc(input string tag);
    m_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask
  task automatic idle_inputs();
    bus.start = '0; bus.dis = '0; bus.count = '0;
  endtask
  initial begin
    idle_inputs();
    m_reset();
    #12;
    check_all("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.start[0] = 1'b1; bus.count[0 +: CNT_W] = 8'd3;
    cyc("bounded");
    bus.start[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc("bounded");
      check("bounded/data_seq", bus.o_data[31:0], 32'(10 + i));
    end
    check("bounded/done", bus.done[0], 1'b1);
    check("bounded/exit_dis", bus.exit_dis[0], 1'b0);
    cyc("bounded");
    check("bounded/iter_hold", bus.iter[7:0], 8'd3);
    bus.start[1] = 1'b1; bus.count[CNT_W +: CNT_W] = '0;
    cyc("forever");
    bus.start[1] = 1'b0;
    repeat (5) cyc("forever");
    bus.dis[1] = 1'b1;
    cyc("forever_dis");
    bus.dis[1] = 1'b0;
    check("forever_dis/data", bus.o_data[63:32], 32'd14);
    check("forever_dis/iter", bus.iter[15:8], 8'd5);
    check("forever_dis/exit_dis", bus.exit_dis[1], 1'b1);
    cyc("forever");
    bus.start[1] = 1'b1;
    cyc("wrap");
    bus.start[1] = 1'b0;
    for (int i = 0; i < 258; i++) cyc("wrap");
    check("wrap/iter", bus.iter[15:8], 8'd2);
    check("wrap/busy", bus.busy[1], 1'b1);
    bus.dis[1] = 1'b1;
    cyc("wrap");
    bus.dis[1] = 1'b0;
    cyc("wrap");
    bus.start[2] = 1'b1; bus.count[2*CNT_W +: CNT_W] = 8'd2;
    cyc("last_dis");
    bus.count[2*CNT_W +: CNT_W] = 8'd9;
    cyc("last_dis");
    bus.dis[2] = 1'b1;
    cyc("last_dis");
    bus.dis[2] = 1'b0;
    check("last_dis/iter", bus.iter[23:16], 8'd1);
    check("last_dis/data", bus.o_data[95:64], 32'd10);
    check("last_dis/exit_dis", bus.exit_dis[2], 1'b1);
    cyc("last_dis");
    bus.start[2] = 1'b0;
    check("last_dis/busy", bus.busy[2], 1'b0);
    for (int i = 0; i < 2000; i++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        bus.start[c] = $urandom_range(0, 3) == 0;
        bus.dis[c] = $urandom_range(0, 7) == 0;
        bus.count[c*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 6));
      end
      cyc("random");
    end
    idle_inputs();
    repeat (12) cyc("drain");
    bus.start = 4'b1111;
    for (int c = 0; c < NUM_CH; c++) bus.count[c*CNT_W +: CNT_W] = CNT_W'(40 + c);
    cyc("reset_mid");
    bus.start = '0;
    repeat (4) cyc("reset_mid");
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    check_all("async_reset");
    check("async_reset/data3", bus.o_data[127:96], 32'd1);
    repeat (2) begin
      @(posedge clk);
      #1;
      check("async_reset/no_done", bus.done, 4'b0);
    end
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.start[3] = 1'b1; bus.count[3*CNT_W +: CNT_W] = 8'd2;
    cyc("after_reset");
    bus.start[3] = 1'b0;
    repeat (4) cyc("after_reset");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/loop_disable_ctrl.md
Name: loop_disable_ctrl

Overview:
Multi-channel hardware loop sequencer: the synthesizable successor to the forever/disable parse test.
- Each channel runs either a bounded loop of N iterations or a forever loop.
- Any running loop can be terminated early by a per-channel disable (break), mirroring `disable <block>`.
- Sits beside the simple_tests fixtures as a clocked, checkable model of loop-exit semantics for the UHDM flow.

Parameters:
NUM_CH, 4, number of independent loop channels
CNT_W, 8, iteration-count width; count value 0 selects forever mode
DATA_W, 32, width of per-channel data output
INIT_VAL, 1, data output value after reset
LOOP_VAL, 10, base value written on each iteration

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
start  input  NUM_CH  per-channel start pulse
count  input  NUM_CH*CNT_W  per-channel iteration count, channel c at [c*CNT_W +: CNT_W]; sampled on accepted start
dis  input  NUM_CH  per-channel disable (break) request
o_data  output  NUM_CH*DATA_W  per-channel data, channel c at [c*DATA_W +: DATA_W]
busy  output  NUM_CH  channel in RUN
done  output  NUM_CH  one-cycle exit pulse
exit_dis  output  NUM_CH  valid with done: 1 = exited by disable/watchdog, 0 = natural completion
iter  output  NUM_CH*CNT_W  per-channel iterations completed

Behaviour:
- Reset values (asynchronous, rst_n low): state IDLE, busy=0, done=0, exit_dis=0, iter=0, o_data=INIT_VAL for every channel.
- Per-channel FSM: IDLE -> RUN -> EXIT -> IDLE.
- IDLE:
  - start=1 latches count into cnt_q, clears iter, and goes to RUN next cycle.
  - dis in IDLE is ignored.
- RUN:
  - One iteration per cycle.
  - o_data <= LOOP_VAL + iter, zero-extended to DATA_W.
  - iter <= iter+1.
  - busy=1.
- Bounded mode (cnt_q != 0):
  - After the cycle that makes iter == cnt_q, go to EXIT with exit_dis=0.
  - Total latency from start to done is cnt_q+1 cycles.
- Forever mode (cnt_q == 0):
  - Never exits naturally.
  - iter wraps 2^CNT_W-1 -> 0; this is legal and does not exit.
- Disable:
  - dis=1 in RUN is acted on that cycle: no iteration executes, and o_data and iter hold.
  - Next state EXIT with exit_dis=1.
  - Same-cycle dis and final iteration: dis wins, the iteration is not executed, exit_dis=1.
- EXIT:
  - done=1 for exactly one cycle; exit_dis is valid; busy=0; go to IDLE.
  - o_data and iter hold their final values until the next start.
- Start while RUN or EXIT is ignored; there is no queueing.
- Start in the same cycle as dis while in IDLE: start is accepted and dis is ignored.
- Channels are fully independent; there is no shared arbitration.
- Reset mid-RUN aborts immediately to reset values; no done pulse is issued.

Optional Feature:
Macro LOOP_WATCHDOG_EN.
- Defined:
  - Adds parameter WD_W (default 12) and output wd_fire (NUM_CH).
  - Each channel has a WD_W-bit cycle counter that is cleared on start and increments in RUN in forever mode only.
  - When the counter reaches 2^WD_W-1, the channel takes an internal disable: it exits as for dis, with exit_dis=1, and wd_fire pulses together with done.
  - A real dis in the same cycle yields the same exit, with wd_fire=1.
- Undefined: no watchdog logic, no wd_fire port, and forever loops run until dis.

Decomposition:
- Package loop_ctrl_pkg:
  - typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_EXIT} loop_state_e
  - typedef enum logic {EXIT_NATURAL, EXIT_DISABLE} exit_cause_e
  - constant FOREVER_CNT = '0
- Sub-module loop_ch: one channel FSM, counter, data register and watchdog, instantiated NUM_CH times via generate.
- The top level only slices the flattened ports.

Test Plan:
1. Reset, then check ch0 idle -> o_data=1, iter=0, busy=0, done=0 on all channels.
2. ch0 start with count=3 -> o_data 10,11,12 on successive cycles; done with exit_dis=0 on cycle 4 after start; iter=3 held.
3. ch1 start with count=0 (forever), dis after 5 RUN cycles -> o_data=14, iter=5, done with exit_dis=1; forever mode with CNT_W=4 shows iter wrapping 15->0 with no done.
4. ch2 count=2, dis asserted on the final iteration cycle -> iter=1, o_data=10, exit_dis=1; start pulses during RUN are ignored.
5. rst_n dropped mid-RUN on ch3 -> asynchronous return to o_data=1 and busy=0, no done pulse; channels 0-2 behave independently in parallel.
6. With LOOP_WATCHDOG_EN and WD_W=4, a forever loop and no dis -> done, exit_dis=1 and wd_fire=1 after 15 RUN cycles.
